sys1_coin_conditioner: RTL and testbench

// - Conditions raw coin switches (keyboard/joystick OR-ed, active-high) before they reach INP2 of the System 1 core.
// - Per channel: debounce, queue coin events, then emit clean fixed-width active-low coin pulses with an enforced gap.
// - Each pulse is wide enough for the game CPU's vblank-polled coin logic to see it.
// - Sits between the input-mapping logic and the core input port; runs on clk_sys.

---
 rtl/sys1_coin_conditioner.sv | 161 ++++++++++++++++
 tb/tb_sys1_coin_conditioner.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sys1_coin_conditioner.sv
// Coin switch conditioner for the System 1 INP2 port: each channel is debounced,
// coin events are queued, and every coin is re-emitted as a fixed active-low pulse plus gap.
`timescale 1ns/1ps
module sys1_coin_conditioner #(
   parameter int TICK_DIV    = 48000,
   parameter int DEB_TICKS   = 5,
   parameter int PULSE_TICKS = 100,
   parameter int GAP_TICKS   = 100,
   parameter int QMAX        = 7
) (
   input  logic       clk_sys,
   input  logic       reset,
   input  logic [1:0] coin_in,
   output logic [1:0] coin_out_n,
   output logic [1:0] coin_busy,
   output logic [1:0] coin_ovf
);
   localparam int DIV_W   = $clog2(TICK_DIV);
   localparam int DEB_W   = (DEB_TICKS > 1) ? $clog2(DEB_TICKS) : 1;
   localparam int PEND_W  = $clog2(QMAX + 1);
   localparam int TMR_MAX = (PULSE_TICKS > GAP_TICKS) ? PULSE_TICKS : GAP_TICKS;
   localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_PULSE = 2'd1,
      S_GAP   = 2'd2
   } state_t;

   logic [DIV_W-1:0] div_q, div_d;
   logic             tick;

   // Shared timebase: one tick per TICK_DIV clocks, paces debounce and pulse timers.
   assign tick = (div_q == DIV_W'(TICK_DIV - 1));

   always_comb begin
      div_d = div_q + DIV_W'(1);
      if (tick) div_d = '0;
   end

   always_ff @(posedge clk_sys) begin
      if (reset) div_q <= '0;
      else       div_q <= div_d;
   end

   for (genvar g = 0; g < 2; g++) begin : g_ch
      logic              deb_q, deb_d;
      logic [DEB_W-1:0]  dcnt_q, dcnt_d;
      logic              evt_q, evt_d;
      logic [PEND_W-1:0] pend_q, pend_d;
      state_t            st_q, st_d;
      logic [TMR_W-1:0]  tmr_q, tmr_d;
      logic              out_n_q, out_n_d;
      logic              busy_q, busy_d;
      logic              ovf_q, ovf_d;
      logic              deq;

      // Debounce: evt flags the cycle deb is accepted high (rising edge only).
      always_comb begin
         deb_d  = deb_q;
         dcnt_d = dcnt_q;
         evt_d  = 1'b0;
         if (tick) begin
            if (coin_in[g] == deb_q) begin
               dcnt_d = '0;
            end else if (dcnt_q == DEB_W'(DEB_TICKS - 1)) begin
               deb_d  = coin_in[g];
               dcnt_d = '0;
               evt_d  = coin_in[g];
            end else begin
               dcnt_d = dcnt_q + DEB_W'(1);
            end
         end
      end

      // Pending queue: an event coinciding with a dequeue nets to no change and never overflows.
      always_comb begin
         pend_d = pend_q;
         ovf_d  = 1'b0;
         if (evt_q && !deq) begin
            if (pend_q == PEND_W'(QMAX)) ovf_d  = 1'b1;
            else                         pend_d = pend_q + PEND_W'(1);
         end else if (!evt_q && deq) begin
            pend_d = pend_q - PEND_W'(1);
         end
      end

      always_comb begin
         st_d  = st_q;
         tmr_d = tmr_q;
         deq   = 1'b0;
         case (st_q)
            S_IDLE: begin
               if (pend_q != '0) begin
                  st_d  = S_PULSE;
                  tmr_d = '0;
                  deq   = 1'b1;
               end
            end
            S_PULSE: begin
               if (tick) begin
                  if (tmr_q == TMR_W'(PULSE_TICKS - 1)) begin
                     st_d  = S_GAP;
                     tmr_d = '0;
                  end else begin
                     tmr_d = tmr_q + TMR_W'(1);
                  end
               end
            end
            S_GAP: begin
               if (tick) begin
                  if (tmr_q == TMR_W'(GAP_TICKS - 1)) st_d  = S_IDLE;
                  else                                tmr_d = tmr_q + TMR_W'(1);
               end
            end
            default: st_d = S_IDLE;
         endcase
      end

      // Outputs are registered from next-state values so the pin moves on the transition edge.
      always_comb begin
         out_n_d = (st_d != S_PULSE);
         busy_d  = (st_d != S_IDLE) || (pend_d != '0);
      end

      always_ff @(posedge clk_sys) begin
         if (reset) begin
            st_q  <= S_IDLE;
            tmr_q <= '0;
         end else begin
            st_q  <= st_d;
            tmr_q <= tmr_d;
         end
      end

      always_ff @(posedge clk_sys) begin
         if (reset) begin
            deb_q   <= 1'b0;
            dcnt_q  <= '0;
            evt_q   <= 1'b0;
            pend_q  <= '0;
            out_n_q <= 1'b1;
            busy_q  <= 1'b0;
            ovf_q   <= 1'b0;
         end else begin
            deb_q   <= deb_d;
            dcnt_q  <= dcnt_d;
            evt_q   <= evt_d;
            pend_q  <= pend_d;
            out_n_q <= out_n_d;
            busy_q  <= busy_d;
            ovf_q   <= ovf_d;
         end
      end

      assign coin_out_n[g] = out_n_q;
      assign coin_busy[g]  = busy_q;
      assign coin_ovf[g]   = ovf_q;
   end

endmodule

// File: tb/tb_sys1_coin_conditioner.sv
// Scoreboard bench for sys1_coin_conditioner: expected pulses are queued as presses are
// driven and matched against pulses collected from the outputs.
`timescale 1ns/1ps
module tb_sys1_coin_conditioner;
   logic       clk = 1'b0;
   logic       rst;
   logic [1:0] coin_a, coin_b;
   logic [1:0] on_a, busy_a, ovf_a;
   logic [1:0] on_b, busy_b, ovf_b;
   int         cyc = 0;
   int         checks = 0;
   int         errors = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   sys1_coin_conditioner #(
      .TICK_DIV(4), .DEB_TICKS(2), .PULSE_TICKS(3), .GAP_TICKS(2), .QMAX(3)
   ) dut (
      .clk_sys(clk), .reset(rst), .coin_in(coin_a),
      .coin_out_n(on_a), .coin_busy(busy_a), .coin_ovf(ovf_a)
   );

   // Longer pulse so five presses fit inside the first pulse and the queue can fill.
   sys1_coin_conditioner #(
      .TICK_DIV(4), .DEB_TICKS(2), .PULSE_TICKS(40), .GAP_TICKS(2), .QMAX(3)
   ) dut_b (
      .clk_sys(clk), .reset(rst), .coin_in(coin_b),
      .coin_out_n(on_b), .coin_busy(busy_b), .coin_ovf(ovf_b)
   );

   typedef struct { int inst; int ch; int fall; int rise; } pulse_t;
   typedef struct { int inst; int ch; int wmin; int wmax; } exp_t;

   pulse_t     obs_q[$];
   exp_t       exp_q[$];
   logic [1:0] mon_on [2];
   logic [1:0] mon_busy [2];
   logic [1:0] mon_ovf [2];
   logic [1:0] on_prev [2];
   logic [1:0] busy_prev [2];
   int         fall_cnt [2][2];
   int         fall_at [2][2];
   int         busy_fall_at [2][2];
   int         ovf_cnt [2][2];
   int         ovf_at [2][2];

   assign mon_on[0]   = on_a;
   assign mon_on[1]   = on_b;
   assign mon_busy[0] = busy_a;
   assign mon_busy[1] = busy_b;
   assign mon_ovf[0]  = ovf_a;
   assign mon_ovf[1]  = ovf_b;

   always @(negedge clk) begin
      for (int i = 0; i < 2; i++) begin
         for (int c = 0; c < 2; c++) begin
            if (on_prev[i][c] && !mon_on[i][c]) begin
               fall_cnt[i][c]++;
               fall_at[i][c] = cyc;
            end
            if (!on_prev[i][c] && mon_on[i][c])
               obs_q.push_back('{inst: i, ch: c, fall: fall_at[i][c], rise: cyc});
            if (busy_prev[i][c] && !mon_busy[i][c]) busy_fall_at[i][c] = cyc;
            if (mon_ovf[i][c]) begin
               ovf_cnt[i][c]++;
               ovf_at[i][c] = cyc;
            end
         end
         on_prev[i]   = mon_on[i];
         busy_prev[i] = mon_busy[i];
      end
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic settle();
      @(negedge clk);
      #1;
   endtask

   task automatic test_reset();
      bit bad;
      logic [1:0] bo, bb, bv;
      rst = 1'b1; coin_a = 2'b00; coin_b = 2'b00;
      step(5);
      settle();
      checks++; if (on_a !== 2'b11) begin errors++; $display("FAIL reset_out_n got %b want 11", on_a); end
      checks++; if (busy_a !== 2'b00) begin errors++; $display("FAIL reset_busy got %b want 00", busy_a); end
      checks++; if (ovf_a !== 2'b00) begin errors++; $display("FAIL reset_ovf got %b want 00", ovf_a); end
      checks++; if (on_b !== 2'b11 || busy_b !== 2'b00) begin
         errors++; $display("FAIL reset_b got out_n=%b busy=%b want 11/00", on_b, busy_b);
      end
      step(1);
      rst = 1'b0;
      bad = 1'b0; bo = 2'b11; bb = 2'b00; bv = 2'b00;
      for (int k = 0; k < 100; k++) begin
         settle();
         if (!bad && (on_a !== 2'b11 || busy_a !== 2'b00 || ovf_a !== 2'b00 || on_b !== 2'b11)) begin
            bad = 1'b1; bo = on_a; bb = busy_a; bv = ovf_a;
         end
      end
      checks++; if (bad) begin
         errors++; $display("FAIL idle_after_reset got out_n=%b busy=%b ovf=%b want 11/00/00", bo, bb, bv);
      end
   endtask

   task automatic test_single_coin();
      int f0, f1, press, lat;
      pulse_t p;
      exp_t e;
      obs_q.delete(); exp_q.delete();
      f0 = fall_cnt[0][0]; f1 = fall_cnt[0][1];
      step(1);
      coin_a = 2'b01; press = cyc;
      exp_q.push_back('{inst: 0, ch: 0, wmin: 9, wmax: 12});
      step(40);
      coin_a = 2'b00;
      for (int k = 0; k < 300 && !(obs_q.size() >= 1 && busy_a[0] === 1'b0); k++) settle();
      checks++; if (!(obs_q.size() >= 1 && busy_a[0] === 1'b0)) begin
         errors++; $display("FAIL single_timeout got pulses=%0d busy=%b want 1/0", obs_q.size(), busy_a[0]);
      end
      lat = fall_at[0][0] - press;
      checks++; if (lat < 6 || lat > 12) begin
         errors++; $display("FAIL single_latency got %0d want 6..12 cycles", lat);
      end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front(); p = obs_q.pop_front();
         checks++; if (p.inst !== e.inst || p.ch !== e.ch) begin
            errors++; $display("FAIL single_chan got %0d/%0d want %0d/%0d", p.inst, p.ch, e.inst, e.ch);
         end
         checks++; if (p.rise - p.fall < e.wmin || p.rise - p.fall > e.wmax) begin
            errors++; $display("FAIL single_width got %0d want %0d..%0d", p.rise - p.fall, e.wmin, e.wmax);
         end
         checks++; if (busy_fall_at[0][0] - p.rise < 5) begin
            errors++; $display("FAIL single_gap got %0d want >=5", busy_fall_at[0][0] - p.rise);
         end
      end
      step(20);
      checks++; if (fall_cnt[0][0] - f0 !== 1 || obs_q.size() !== 0) begin
         errors++; $display("FAIL single_count got %0d pulses want 1", fall_cnt[0][0] - f0);
      end
      checks++; if (fall_cnt[0][1] !== f1) begin
         errors++; $display("FAIL single_other_ch got %0d pulses want 0", fall_cnt[0][1] - f1);
      end
   endtask

   task automatic test_glitch();
      int f0;
      bit bad;
      f0 = fall_cnt[0][0];
      bad = 1'b0;
      for (int r = 0; r < 10; r++) begin
         for (int k = 0; k < 20; k++) begin
            coin_a = (k < 3) ? 2'b01 : 2'b00;
            settle();
            if (busy_a !== 2'b00 || on_a !== 2'b11) bad = 1'b1;
            step(1);
         end
      end
      coin_a = 2'b00;
      checks++; if (bad) begin errors++; $display("FAIL glitch_busy got activity want busy=00 out_n=11"); end
      checks++; if (fall_cnt[0][0] !== f0) begin
         errors++; $display("FAIL glitch_pulse got %0d pulses want 0", fall_cnt[0][0] - f0);
      end
   endtask

   task automatic test_both_channels();
      pulse_t p;
      exp_t e;
      obs_q.delete(); exp_q.delete();
      coin_a = 2'b11;
      exp_q.push_back('{inst: 0, ch: 0, wmin: 9, wmax: 12});
      exp_q.push_back('{inst: 0, ch: 1, wmin: 9, wmax: 12});
      step(40);
      coin_a = 2'b00;
      for (int k = 0; k < 300 && !(obs_q.size() >= 2 && busy_a === 2'b00); k++) settle();
      checks++; if (!(obs_q.size() >= 2 && busy_a === 2'b00)) begin
         errors++; $display("FAIL both_timeout got pulses=%0d busy=%b want 2/00", obs_q.size(), busy_a);
      end
      checks++; if (fall_at[0][0] !== fall_at[0][1]) begin
         errors++; $display("FAIL both_align got fall ch0=%0d ch1=%0d want equal", fall_at[0][0], fall_at[0][1]);
      end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front(); p = obs_q.pop_front();
         checks++; if (p.ch !== e.ch || p.rise - p.fall < e.wmin || p.rise - p.fall > e.wmax) begin
            errors++; $display("FAIL both_pulse got ch%0d width %0d want ch%0d width %0d..%0d",
                               p.ch, p.rise - p.fall, e.ch, e.wmin, e.wmax);
         end
      end
      step(20);
   endtask

   task automatic test_burst();
      int f1, f0, o1, o0, p5;
      pulse_t p;
      exp_t e;
      obs_q.delete(); exp_q.delete();
      f1 = fall_cnt[1][1]; f0 = fall_cnt[1][0]; o1 = ovf_cnt[1][1]; o0 = ovf_cnt[1][0];
      p5 = 0;
      for (int n = 0; n < 5; n++) begin
         coin_b = 2'b10;
         if (n < 4) exp_q.push_back('{inst: 1, ch: 1, wmin: 157, wmax: 160});
         else       p5 = cyc;
         step(12);
         coin_b = 2'b00;
         step(12);
      end
      for (int k = 0; k < 1200 && !(obs_q.size() >= 4 && busy_b === 2'b00); k++) settle();
      checks++; if (!(obs_q.size() >= 4 && busy_b === 2'b00)) begin
         errors++; $display("FAIL burst_timeout got pulses=%0d busy=%b want 4/00", obs_q.size(), busy_b);
      end
      checks++; if (ovf_cnt[1][1] - o1 !== 1) begin
         errors++; $display("FAIL burst_ovf_count got %0d want 1", ovf_cnt[1][1] - o1);
      end
      checks++; if (ovf_at[1][1] < p5 || ovf_at[1][1] > p5 + 14) begin
         errors++; $display("FAIL burst_ovf_time got cyc %0d want %0d..%0d", ovf_at[1][1], p5, p5 + 14);
      end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front(); p = obs_q.pop_front();
         checks++; if (p.inst !== e.inst || p.ch !== e.ch || p.rise - p.fall < e.wmin || p.rise - p.fall > e.wmax) begin
            errors++; $display("FAIL burst_pulse got inst%0d ch%0d width %0d want inst%0d ch%0d width %0d..%0d",
                               p.inst, p.ch, p.rise - p.fall, e.inst, e.ch, e.wmin, e.wmax);
         end
      end
      checks++; if (fall_cnt[1][1] - f1 !== 4 || exp_q.size() !== 0) begin
         errors++; $display("FAIL burst_count got %0d pulses want 4", fall_cnt[1][1] - f1);
      end
      checks++; if (fall_cnt[1][0] !== f0 || ovf_cnt[1][0] !== o0) begin
         errors++; $display("FAIL burst_other_ch got pulses=%0d ovf=%0d want 0/0",
                            fall_cnt[1][0] - f0, ovf_cnt[1][0] - o0);
      end
   endtask

   task automatic test_reset_mid_pulse();
      int f0;
      bit bad;
      obs_q.delete(); exp_q.delete();
      for (int n = 0; n < 3; n++) begin
         coin_b = 2'b01;
         step(12);
         coin_b = 2'b00;
         step(12);
      end
      step(4);
      settle();
      checks++; if (on_b[0] !== 1'b0 || busy_b[0] !== 1'b1) begin
         errors++; $display("FAIL midrst_pre got out_n=%b busy=%b want 0/1", on_b[0], busy_b[0]);
      end
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk);
      settle();
      checks++; if (on_b !== 2'b11 || busy_b !== 2'b00 || ovf_b !== 2'b00) begin
         errors++; $display("FAIL midrst_release got out_n=%b busy=%b ovf=%b want 11/00/00", on_b, busy_b, ovf_b);
      end
      step(1);
      rst = 1'b0;
      obs_q.delete();
      f0 = fall_cnt[1][0];
      bad = 1'b0;
      for (int k = 0; k < 400; k++) begin
         settle();
         if (on_b !== 2'b11 || busy_b !== 2'b00) bad = 1'b1;
      end
      checks++; if (bad || fall_cnt[1][0] !== f0) begin
         errors++; $display("FAIL midrst_after got %0d pulses want 0 and idle outputs", fall_cnt[1][0] - f0);
      end
   endtask

   initial begin
      rst = 1'b1;
      coin_a = 2'b00;
      coin_b = 2'b00;
      test_reset();
      test_single_coin();
      test_glitch();
      test_both_channels();
      test_burst();
      test_reset_mid_pulse();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
